// File: rtl/event_arbiter_pkg.sv
// Shared constants, message field layout and FSM encoding for the event arbiter.
package event_arbiter_pkg;

    // Default value carried in the top byte of every event message
    localparam int unsigned MESSAGE_TYPE_DEFAULT = 1;

    // Event type codes (source index + 1)
    localparam logic [7:0] EVT_UNDERFLOW = 8'd1;
    localparam logic [7:0] EVT_OVERFLOW  = 8'd2;

    // Message field positions and widths
    localparam int unsigned TYPE_LSB   = 0;
    localparam int unsigned TYPE_W     = 8;
    localparam int unsigned COUNT_LSB  = 8;
    localparam int unsigned COUNT_W    = 16;
    localparam int unsigned MSG_TYPE_W = 8;

    // Scheduler states
    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } arb_state_t;

    // Occurrence counter increment, sticking at all-ones
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        return (c == '1) ? c : c + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/event_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping.
module event_arbiter_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    // Scan requests starting at ptr; the first hit wins
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned idx;
            idx = (k + 32'(ptr)) % N;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/event_arbiter.sv
// Latches event strobes as pending with saturating occurrence counts and
// schedules them round-robin onto an AXI-Stream event-message bus.
module event_arbiter
    import event_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned NUM_EVENTS   = 4,
    parameter int unsigned MESSAGE_TYPE = MESSAGE_TYPE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_EVENTS-1:0] event_strobe,
    input  logic [NUM_EVENTS-1:0] event_enable,
    output logic [NUM_EVENTS-1:0] pending,
    output logic [DATA_WIDTH-1:0] AXIS_OUT_TDATA,
    output logic                  AXIS_OUT_TVALID,
    input  logic                  AXIS_OUT_TREADY
);

    localparam int unsigned IDX_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

    arb_state_t            state, state_nxt;
    logic [IDX_W-1:0]      rr_ptr;
    logic                  gnt_valid;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  load;
    logic [DATA_WIDTH-1:0] msg;

    logic [COUNT_W-1:0]    cnt     [NUM_EVENTS];
    logic [COUNT_W-1:0]    cnt_nxt [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] pending_nxt;

    event_arbiter_rr_arbiter #(
        .N     (NUM_EVENTS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (pending),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Scheduler state register
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next state: grant from IDLE, return to IDLE on handshake
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Per-source pending/count update; a grant clears first so a same-cycle strobe restarts at 1
    always_comb begin
        pending_nxt = pending;
        for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
            logic               clr;
            logic [COUNT_W-1:0] base;
            cnt_nxt[i] = cnt[i];
            clr  = load && (gnt_idx == IDX_W'(i));
            base = clr ? '0 : cnt[i];
            if (!event_enable[i]) begin
                pending_nxt[i] = 1'b0;
                cnt_nxt[i]     = '0;
            end else if (event_strobe[i]) begin
                pending_nxt[i] = 1'b1;
                cnt_nxt[i]     = sat_inc(base);
            end else if (clr) begin
                pending_nxt[i] = 1'b0;
                cnt_nxt[i]     = '0;
            end
        end
    end

    // Pending and count registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending <= '0;
            for (int unsigned i = 0; i < NUM_EVENTS; i++) cnt[i] <= '0;
        end else begin
            pending <= pending_nxt;
            for (int unsigned i = 0; i < NUM_EVENTS; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    // Message image for the currently granted source
    always_comb begin
        msg = '0;
        msg[DATA_WIDTH-1 -: MSG_TYPE_W] = MSG_TYPE_W'(MESSAGE_TYPE);
        msg[COUNT_LSB +: COUNT_W]       = cnt[gnt_idx];
        msg[TYPE_LSB +: TYPE_W]         = TYPE_W'(gnt_idx) + TYPE_W'(1);
    end

    // Output register and round-robin pointer; data held stable until handshake
    always_ff @(posedge clk) begin
        if (!resetn) begin
            AXIS_OUT_TDATA  <= '0;
            AXIS_OUT_TVALID <= 1'b0;
            rr_ptr          <= '0;
        end else if (load) begin
            AXIS_OUT_TDATA  <= msg;
            AXIS_OUT_TVALID <= 1'b1;
            rr_ptr          <= (gnt_idx == IDX_W'(NUM_EVENTS - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end else if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
            AXIS_OUT_TVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_event_arbiter.sv
// Directed bench for event_arbiter with hand-computed expected messages.
module tb_event_arbiter;

    logic         clk = 1'b0;
    logic         resetn;
    logic [3:0]   event_strobe;
    logic [3:0]   event_enable;
    logic [3:0]   pending;
    logic [255:0] AXIS_OUT_TDATA;
    logic         AXIS_OUT_TVALID;
    logic         AXIS_OUT_TREADY;

    int n_checks = 0;
    int n_pass   = 0;

    event_arbiter #(
        .DATA_WIDTH   (256),
        .NUM_EVENTS   (4),
        .MESSAGE_TYPE (1)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .event_strobe    (event_strobe),
        .event_enable    (event_enable),
        .pending         (pending),
        .AXIS_OUT_TDATA  (AXIS_OUT_TDATA),
        .AXIS_OUT_TVALID (AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY (AXIS_OUT_TREADY)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Expected message: top byte 1, count in [23:8], type in [7:0]
    function automatic logic [255:0] exp_msg(input int t, input int c);
        logic [255:0] m;
        m = '0;
        m[255:248] = 8'd1;
        m[23:8]    = c[15:0];
        m[7:0]     = t[7:0];
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        event_strobe = '0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        resetn          = 1'b0;
        event_strobe    = '0;
        event_enable    = 4'hF;
        AXIS_OUT_TREADY = 1'b0;
        do_reset();
        check("rst_tvalid",  256'(AXIS_OUT_TVALID), 256'd0);
        check("rst_tdata",   AXIS_OUT_TDATA, '0);
        check("rst_pending", 256'(pending), 256'd0);

        // Single strobe on src0, two-cycle latency
        AXIS_OUT_TREADY = 1'b1;
        event_strobe = 4'b0001;
        tick();
        event_strobe = '0;
        check("t1_pend",   256'(pending), 256'h1);
        check("t1_vlow",   256'(AXIS_OUT_TVALID), 256'd0);
        tick();
        check("t1_valid",  256'(AXIS_OUT_TVALID), 256'd1);
        check("t1_data",   AXIS_OUT_TDATA, exp_msg(1, 1));
        check("t1_pclr",   256'(pending), 256'h0);
        tick();
        check("t1_vdrop",  256'(AXIS_OUT_TVALID), 256'd0);

        // Five strobes on src1 under backpressure coalesce into 1 + 4
        do_reset();
        AXIS_OUT_TREADY = 1'b0;
        event_strobe = 4'b0010;
        for (int i = 0; i < 5; i++) tick();
        event_strobe = '0;
        check("t2_valid", 256'(AXIS_OUT_TVALID), 256'd1);
        check("t2_first", AXIS_OUT_TDATA, exp_msg(2, 1));
        for (int i = 0; i < 3; i++) tick();
        check("t2_stable", AXIS_OUT_TDATA, exp_msg(2, 1));
        check("t2_pend",   256'(pending), 256'h2);
        AXIS_OUT_TREADY = 1'b1;
        tick();
        check("t2_gap",    256'(AXIS_OUT_TVALID), 256'd0);
        tick();
        check("t2_valid2", 256'(AXIS_OUT_TVALID), 256'd1);
        check("t2_second", AXIS_OUT_TDATA, exp_msg(2, 4));
        tick();
        check("t2_end",    256'(AXIS_OUT_TVALID), 256'd0);

        // All four sources at once: strict rotation with one idle cycle between messages
        do_reset();
        AXIS_OUT_TREADY = 1'b1;
        event_strobe = 4'b1111;
        tick();
        event_strobe = '0;
        check("t3_pend", 256'(pending), 256'hF);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t3_valid%0d", k), 256'(AXIS_OUT_TVALID), 256'd1);
            check($sformatf("t3_data%0d", k), AXIS_OUT_TDATA, exp_msg(k + 1, 1));
            tick();
            check($sformatf("t3_gap%0d", k), 256'(AXIS_OUT_TVALID), 256'd0);
        end
        check("t3_empty", 256'(pending), 256'h0);

        // Strobe on src2 in its own grant cycle
        do_reset();
        AXIS_OUT_TREADY = 1'b0;
        event_strobe = 4'b0001;
        tick();
        event_strobe = '0;
        tick();
        check("t4_src0", AXIS_OUT_TDATA, exp_msg(1, 1));
        event_strobe = 4'b0100;
        for (int i = 0; i < 3; i++) tick();
        event_strobe = '0;
        check("t4_pend", 256'(pending), 256'h4);
        AXIS_OUT_TREADY = 1'b1;
        tick();
        check("t4_idle", 256'(AXIS_OUT_TVALID), 256'd0);
        event_strobe = 4'b0100;
        tick();
        event_strobe = '0;
        check("t4_msgk",  AXIS_OUT_TDATA, exp_msg(3, 3));
        check("t4_repend", 256'(pending), 256'h4);
        tick();
        tick();
        check("t4_valid1", 256'(AXIS_OUT_TVALID), 256'd1);
        check("t4_msg1",   AXIS_OUT_TDATA, exp_msg(3, 1));
        tick();
        check("t4_done",   256'(pending), 256'h0);

        // 70000 strobes on src3 saturate the count
        do_reset();
        AXIS_OUT_TREADY = 1'b0;
        event_strobe = 4'b1000;
        for (int i = 0; i < 70000; i++) tick();
        event_strobe = '0;
        check("t5_first", AXIS_OUT_TDATA, exp_msg(4, 1));
        check("t5_pend",  256'(pending), 256'h8);
        AXIS_OUT_TREADY = 1'b1;
        tick();
        tick();
        check("t5_sat",   AXIS_OUT_TDATA, exp_msg(4, 16'hFFFF));
        tick();

        // Disabling src3 flushes its pending count but not the message on the bus
        AXIS_OUT_TREADY = 1'b0;
        event_strobe = 4'b1000;
        tick();
        event_strobe = '0;
        tick();
        check("t5_busmsg", AXIS_OUT_TDATA, exp_msg(4, 1));
        event_strobe = 4'b1000;
        for (int i = 0; i < 5; i++) tick();
        event_strobe = '0;
        check("t5_pend3", 256'(pending), 256'h8);
        event_enable = 4'b0111;
        tick();
        check("t5_flush",  256'(pending), 256'h0);
        check("t5_held",   AXIS_OUT_TDATA, exp_msg(4, 1));
        check("t5_hvalid", 256'(AXIS_OUT_TVALID), 256'd1);
        event_strobe = 4'b1000;
        tick();
        event_strobe = '0;
        check("t5_masked", 256'(pending), 256'h0);
        event_enable = 4'hF;
        AXIS_OUT_TREADY = 1'b1;
        tick();
        tick();
        check("t5_nomore", 256'(AXIS_OUT_TVALID), 256'd0);

        // Reset during SEND discards the message; counting restarts afterwards
        AXIS_OUT_TREADY = 1'b0;
        event_strobe = 4'b0010;
        tick();
        event_strobe = 4'b0100;
        tick();
        event_strobe = '0;
        check("t6_send", 256'(AXIS_OUT_TVALID), 256'd1);
        resetn = 1'b0;
        tick();
        check("t6_vrst", 256'(AXIS_OUT_TVALID), 256'd0);
        check("t6_prst", 256'(pending), 256'h0);
        check("t6_drst", AXIS_OUT_TDATA, '0);
        resetn = 1'b1;
        event_strobe = 4'b0010;
        tick();
        event_strobe = '0;
        tick();
        check("t6_after", AXIS_OUT_TDATA, exp_msg(2, 1));
        check("t6_vafter", 256'(AXIS_OUT_TVALID), 256'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
